// File: rtl/fret_scanner_n_pkg.sv
// Shared definitions for the fret scanner: strum FSM states, LanePos field
// layout and a helper for the strum pulse length.
package fret_scanner_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STRUM = 2'd1,
    ST_GAP   = 2'd2
  } strum_state_e;

  // Per-lane LanePos word: {2'b0, y[9:0], 1'b0, x[10:0]}
  localparam int X_LSB     = 0;
  localparam int X_W       = 11;
  localparam int Y_LSB     = 12;
  localparam int Y_W       = 10;
  localparam int LANE_BITS = 24;

  // A zero strum time still gives a one-frame pulse.
  function automatic logic [3:0] strum_len(input logic [3:0] t);
    return (t == 4'd0) ? 4'd1 : t;
  endfunction

endpackage

// File: rtl/fret_scanner_n_lane.sv
// fret_lane: one detection lane. Counts lit pixels inside the lane window
// during a frame and debounces the per-frame hit decision into a fret state.
//   clk, rst      : clock, synchronous active-high reset
//   hit_en        : VDE & Pixel for a countable cycle
//   commit        : end of a valid frame, evaluate and debounce
//   clear         : frame boundary, restart the pixel count
//   col, line     : current raster position
//   pos_x, pos_y  : window origin (shadowed for the frame)
//   fret_o        : debounced fret state
module fret_lane
  import fret_scanner_n_pkg::*;
#(
  parameter int WIN_W    = 8,
  parameter int WIN_H    = 4,
  parameter int THRESH   = 16,
  parameter int DEBOUNCE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hit_en,
  input  logic           commit,
  input  logic           clear,
  input  logic [X_W-1:0] col,
  input  logic [Y_W-1:0] line,
  input  logic [X_W-1:0] pos_x,
  input  logic [Y_W-1:0] pos_y,
  output logic           fret_o
);

  localparam int CNT_W = $clog2(WIN_W * WIN_H + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       agree_q, agree_d;
  logic             fret_q, fret_d;
  logic [X_W:0]     x_end;
  logic [Y_W:0]     y_end;
  logic             in_win, frame_hit;

  // One extra bit on the window end so a window near the right/bottom
  // edge clips instead of wrapping around to column/line 0.
  assign x_end  = {1'b0, pos_x} + (X_W+1)'(WIN_W - 1);
  assign y_end  = {1'b0, pos_y} + (Y_W+1)'(WIN_H - 1);
  assign in_win = (col >= pos_x) && ({1'b0, col} <= x_end) &&
                  (line >= pos_y) && ({1'b0, line} <= y_end);
  assign frame_hit = 32'(cnt_q) >= THRESH;

  always_comb begin
    cnt_d   = cnt_q;
    agree_d = agree_q;
    fret_d  = fret_q;
    // Frame boundary wins: a pixel on the vEdge cycle is dropped.
    if (clear)
      cnt_d = '0;
    else if (hit_en && in_win && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
    if (commit) begin
      if (frame_hit != fret_q) begin
        if (32'(agree_q) + 1 >= DEBOUNCE) begin
          fret_d  = ~fret_q;
          agree_d = '0;
        end else begin
          agree_d = agree_q + 4'd1;
        end
      end else begin
        agree_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      agree_q <= '0;
      fret_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      agree_q <= agree_d;
      fret_q  <= fret_d;
    end
  end

  assign fret_o = fret_q;

endmodule

// File: rtl/fret_scanner_n.sv
// fret_scanner_n: scans a thresholded video stream for lit fret windows,
// debounces them per lane and generates a frame-timed strum pulse.
//   CLK, RST          : pixel clock, synchronous active-high reset
//   Enable            : gates Frets/Strum only
//   HSync/VSync/VDE   : video timing; Pixel: thresholded pixel
//   LanePos           : per-lane window origin, lane 0 at LSBs
//   StrumTime         : strum pulse length in frames
//   Frets, Strum      : gated outputs
//   FrameDone         : pulse when a frame result is committed
//   Status            : {strum state, ungated Frets}
module fret_scanner_n
  import fret_scanner_n_pkg::*;
#(
  parameter int NUM_LANES = 5,
  parameter int WIN_W     = 8,
  parameter int WIN_H     = 4,
  parameter int THRESH    = 16,
  parameter int DEBOUNCE  = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           Enable,
  input  logic                           HSync,
  input  logic                           VSync,
  input  logic                           VDE,
  input  logic                           Pixel,
  input  logic [LANE_BITS*NUM_LANES-1:0] LanePos,
  input  logic [3:0]                     StrumTime,
  output logic [NUM_LANES-1:0]           Frets,
  output logic                           Strum,
  output logic                           FrameDone,
  output logic [NUM_LANES+1:0]           Status
);

  // Two sync stages plus one delay stage for edge detection.
  logic [2:0] hs_q, hs_d, vs_q, vs_d;
  logic       h_edge, v_edge;
  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] line_q, line_d;
  logic           line_vde_q, line_vde_d;
  logic           frame_vld_q, frame_vld_d;
  logic           done_q, done_d;
  logic [NUM_LANES-1:0][X_W-1:0] pos_x_q, pos_x_d;
  logic [NUM_LANES-1:0][Y_W-1:0] pos_y_q, pos_y_d;
  logic [NUM_LANES-1:0]          frets, pad_unused;
  strum_state_e                  state_q, state_d;
  logic [NUM_LANES-1:0]          chord_q, chord_d;
  logic [3:0]                    scnt_q, scnt_d;
  logic                          hit_en, commit, strum_raw;

  assign hs_d   = {hs_q[1:0], HSync};
  assign vs_d   = {vs_q[1:0], VSync};
  assign h_edge = hs_q[1] & ~hs_q[2];
  assign v_edge = vs_q[1] & ~vs_q[2];

  // frame_vld stays low after reset until a vEdge, so a partial frame
  // never produces a result.
  assign hit_en = VDE & Pixel & frame_vld_q & ~v_edge;
  assign commit = v_edge & frame_vld_q;

  always_comb begin
    col_d = col_q;
    if (h_edge)                  col_d = '0;
    else if (VDE && col_q != '1) col_d = col_q + 11'd1;

    line_d = line_q;
    if (v_edge)                                    line_d = '0;
    else if (h_edge && line_vde_q && line_q != '1) line_d = line_q + 10'd1;

    line_vde_d = line_vde_q;
    if (v_edge || h_edge) line_vde_d = 1'b0;
    else if (VDE)         line_vde_d = 1'b1;

    frame_vld_d = frame_vld_q | v_edge;
    done_d      = commit;

    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (v_edge) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        pos_x_d[i] = LanePos[i*LANE_BITS+X_LSB +: X_W];
        pos_y_d[i] = LanePos[i*LANE_BITS+Y_LSB +: Y_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_q        <= '0;
      vs_q        <= '0;
      col_q       <= '0;
      line_q      <= '0;
      line_vde_q  <= 1'b0;
      frame_vld_q <= 1'b0;
      done_q      <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      col_q       <= col_d;
      line_q      <= line_d;
      line_vde_q  <= line_vde_d;
      frame_vld_q <= frame_vld_d;
      done_q      <= done_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // Padding bits of each LanePos word carry no information.
    assign pad_unused[i] = ^{LanePos[i*LANE_BITS+X_W], LanePos[i*LANE_BITS+Y_LSB+Y_W +: 2]};
    fret_lane #(
      .WIN_W(WIN_W), .WIN_H(WIN_H), .THRESH(THRESH), .DEBOUNCE(DEBOUNCE)
    ) u_lane (
      .clk(CLK), .rst(RST), .hit_en(hit_en), .commit(commit), .clear(v_edge),
      .col(col_q), .line(line_q), .pos_x(pos_x_q[i]), .pos_y(pos_y_q[i]),
      .fret_o(frets[i])
    );
  end

  // Strum FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      chord_q <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      chord_q <= chord_d;
      scnt_q  <= scnt_d;
    end
  end

  // Strum FSM: next state, only advanced on committed frames
  always_comb begin
    state_d = state_q;
    chord_d = chord_q;
    scnt_d  = scnt_q;
    if (done_q) begin
      case (state_q)
        ST_IDLE: begin
          if (frets != '0 && frets != chord_q) begin
            state_d = ST_STRUM;
            chord_d = frets;
            scnt_d  = strum_len(StrumTime);
          end else if (frets == '0) begin
            chord_d = '0;
          end
        end
        ST_STRUM: begin
          if (frets != '0 && frets != chord_q) begin
            state_d = ST_GAP;
          end else begin
            // Release forgets the chord but the pulse runs to its length.
            if (frets == '0) chord_d = '0;
            if (scnt_q <= 4'd1) state_d = ST_IDLE;
            else                scnt_d  = scnt_q - 4'd1;
          end
        end
        ST_GAP: begin
          state_d = ST_STRUM;
          chord_d = frets;
          scnt_d  = strum_len(StrumTime);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strum FSM: outputs
  always_comb begin
    strum_raw = (state_q == ST_STRUM);
    Frets     = frets & {NUM_LANES{Enable}};
    Strum     = strum_raw & Enable;
    FrameDone = done_q;
    Status    = {state_q, frets};
  end

endmodule

// File: tb/tb_fret_scanner_n.sv
module tb_fret_scanner_n;
  localparam int NL = 5;

  logic CLK = 1'b0, RST = 1'b1, Enable = 1'b1;
  logic HSync = 1'b0, VSync = 1'b0, VDE = 1'b0, Pixel = 1'b0;
  logic [24*NL-1:0] LanePos = '0;
  logic [3:0] StrumTime = 4'd3;
  logic [NL-1:0] Frets;
  logic Strum, FrameDone;
  logic [NL+1:0] Status;

  int checks = 0, errors = 0, fd_cnt = 0;
  int rx[4], ry[4], rw[4], rh[4];
  int nrect = 0;

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (FrameDone === 1'b1) fd_cnt++;

  fret_scanner_n dut (
    .CLK(CLK), .RST(RST), .Enable(Enable), .HSync(HSync), .VSync(VSync),
    .VDE(VDE), .Pixel(Pixel), .LanePos(LanePos), .StrumTime(StrumTime),
    .Frets(Frets), .Strum(Strum), .FrameDone(FrameDone), .Status(Status)
  );

  task automatic set_lane(input int i, input int x, input int y);
    logic [23:0] p;
    p = '0;
    p[21:12] = y[9:0];
    p[10:0]  = x[10:0];
    LanePos[i*24 +: 24] = p;
  endtask

  task automatic add_rect(input int x, input int y, input int w, input int h);
    rx[nrect] = x; ry[nrect] = y; rw[nrect] = w; rh[nrect] = h;
    nrect++;
  endtask

  function automatic logic lit(input int l, input int c);
    for (int k = 0; k < nrect; k++)
      if (c >= rx[k] && c < rx[k] + rw[k] && l >= ry[k] && l < ry[k] + rh[k]) return 1'b1;
    return 1'b0;
  endfunction

  // VSync pulse, then nl lines; lines wlo..whi are ww pixels wide, others 1.
  task automatic do_frame(input int nl, input int wlo, input int whi, input int ww);
    int w;
    @(negedge CLK); VSync = 1'b1;
    @(negedge CLK); VSync = 1'b0;
    repeat (8) @(negedge CLK);
    for (int l = 0; l < nl; l++) begin
      HSync = 1'b1; @(negedge CLK); HSync = 1'b0;
      repeat (3) @(negedge CLK);
      w = (l >= wlo && l <= whi) ? ww : 1;
      for (int c = 0; c < w; c++) begin
        VDE = 1'b1; Pixel = lit(l, c); @(negedge CLK);
      end
      VDE = 1'b0; Pixel = 1'b0; @(negedge CLK);
    end
  endtask

  task automatic small_frame(); do_frame(54, 50, 53, 130); endtask
  task automatic edge_frame();  do_frame(4, 0, 3, 2048);   endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (Frets !== 5'b0) begin errors++; $display("FAIL reset_frets: got %b want 00000", Frets); end
    checks++; if (Strum !== 1'b0) begin errors++; $display("FAIL reset_strum: got %b want 0", Strum); end
    checks++; if (FrameDone !== 1'b0) begin errors++; $display("FAIL reset_framedone: got %b want 0", FrameDone); end
    checks++; if (Status !== 7'b0) begin errors++; $display("FAIL reset_status: got %b want 0000000", Status); end
    RST = 1'b0;
  endtask

  task automatic test_press();
    int fd0;
    logic [3:0] exp_s [4] = '{1, 1, 1, 0};
    set_lane(0, 100, 50); set_lane(1, 120, 1000);
    set_lane(2, 0, 1000); set_lane(3, 0, 1000); set_lane(4, 0, 1000);
    nrect = 0; add_rect(100, 50, 8, 4);
    fd0 = fd_cnt; small_frame();
    checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL press_arm_fd: got %0d want 0", fd_cnt - fd0); end
    fd0 = fd_cnt; small_frame();
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL press_fd: got %0d want 1", fd_cnt - fd0); end
    checks++; if (Frets !== 5'b00000) begin errors++; $display("FAIL press_first: got %b want 00000", Frets); end
    small_frame();
    checks++; if (Frets !== 5'b00001) begin errors++; $display("FAIL press_second: got %b want 00001", Frets); end
    checks++; if (Status !== 7'b0100001) begin errors++; $display("FAIL press_status: got %b want 0100001", Status); end
    checks++; if (Strum !== 1'b1) begin errors++; $display("FAIL press_strum0: got %b want 1", Strum); end
    for (int n = 1; n < 4; n++) begin
      small_frame();
      checks++; if (Strum !== exp_s[n][0]) begin errors++; $display("FAIL press_strum%0d: got %b want %b", n, Strum, exp_s[n][0]); end
    end
    small_frame();
    checks++; if (Strum !== 1'b0) begin errors++; $display("FAIL press_nore: got %b want 0", Strum); end
  endtask

  task automatic test_chord_change();
    logic [0:0] exp_s [4] = '{0, 1, 1, 1};
    set_lane(1, 120, 50);
    nrect = 0;
    small_frame(); small_frame();
    nrect = 0; add_rect(100, 50, 8, 4);
    small_frame();
    checks++; if (Frets !== 5'b00000) begin errors++; $display("FAIL chord_release: got %b want 00000", Frets); end
    small_frame();
    add_rect(120, 50, 8, 4);
    small_frame();
    checks++; if (Frets !== 5'b00001 || Strum !== 1'b1) begin errors++; $display("FAIL chord_strum1: got %b/%b want 00001/1", Frets, Strum); end
    small_frame();
    checks++; if (Strum !== 1'b1) begin errors++; $display("FAIL chord_strum2: got %b want 1", Strum); end
    small_frame();
    checks++; if (Frets !== 5'b00011) begin errors++; $display("FAIL chord_frets: got %b want 00011", Frets); end
    checks++; if (Status[6:5] !== 2'd2 || Strum !== exp_s[0][0]) begin errors++; $display("FAIL chord_gap: got %0d/%b want 2/0", Status[6:5], Strum); end
    for (int n = 1; n < 4; n++) begin
      small_frame();
      checks++; if (Strum !== exp_s[n][0]) begin errors++; $display("FAIL chord_strum_new%0d: got %b want %b", n, Strum, exp_s[n][0]); end
    end
    small_frame();
    checks++; if (Strum !== 1'b0 || Frets !== 5'b00011) begin errors++; $display("FAIL chord_end: got %b/%b want 00011/0", Frets, Strum); end
  endtask

  task automatic test_threshold();
    nrect = 0;
    small_frame(); small_frame();
    add_rect(100, 50, 5, 3);
    small_frame();
    checks++; if (Frets !== 5'b00000) begin errors++; $display("FAIL thr_release: got %b want 00000", Frets); end
    for (int n = 0; n < 6; n++) begin
      if (n == 5) begin nrect = 0; add_rect(100, 50, 8, 2); end
      small_frame();
      checks++; if (Frets !== 5'b00000 || Strum !== 1'b0) begin errors++; $display("FAIL thr_15px_%0d: got %b/%b want 00000/0", n, Frets, Strum); end
    end
    small_frame();
    checks++; if (Frets !== 5'b00000) begin errors++; $display("FAIL thr_16_first: got %b want 00000", Frets); end
    small_frame();
    checks++; if (Frets !== 5'b00001 || Strum !== 1'b1) begin errors++; $display("FAIL thr_16_press: got %b/%b want 00001/1", Frets, Strum); end
  endtask

  task automatic test_alternate();
    for (int n = 0; n < 6; n++) begin
      nrect = 0;
      if (n % 2 == 1) add_rect(100, 50, 8, 2);
      small_frame();
      checks++; if (Frets !== 5'b00001) begin errors++; $display("FAIL alt_%0d: got %b want 00001", n, Frets); end
    end
  endtask

  task automatic test_edge();
    set_lane(0, 100, 1000); set_lane(1, 120, 1000);
    set_lane(2, 2045, 0); set_lane(3, 2040, 0); set_lane(4, 0, 1000);
    nrect = 0; add_rect(0, 0, 8, 4); add_rect(2040, 0, 8, 4);
    edge_frame(); edge_frame();
    checks++; if (Frets !== 5'b00001) begin errors++; $display("FAIL edge_first: got %b want 00001", Frets); end
    edge_frame();
    checks++; if (Frets !== 5'b01000) begin errors++; $display("FAIL edge_nowrap: got %b want 01000", Frets); end
    checks++; if (Strum !== 1'b1) begin errors++; $display("FAIL edge_strum: got %b want 1", Strum); end
  endtask

  task automatic test_reset_enable();
    int fd0;
    Enable = 1'b0; #1;
    checks++; if (Frets !== 5'b0 || Strum !== 1'b0) begin errors++; $display("FAIL en_gate: got %b/%b want 00000/0", Frets, Strum); end
    checks++; if (Status !== 7'b0101000) begin errors++; $display("FAIL en_status: got %b want 0101000", Status); end
    Enable = 1'b1; #1;
    checks++; if (Frets !== 5'b01000 || Strum !== 1'b1) begin errors++; $display("FAIL en_ungate: got %b/%b want 01000/1", Frets, Strum); end
    set_lane(0, 100, 50); set_lane(2, 0, 1000); set_lane(3, 0, 1000);
    nrect = 0; add_rect(100, 50, 8, 4);
    do_frame(52, 50, 53, 130);
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (Frets !== 5'b0 || Strum !== 1'b0 || FrameDone !== 1'b0 || Status !== 7'b0) begin
      errors++; $display("FAIL rst_mid: got %b/%b/%b/%b want all zero", Frets, Strum, FrameDone, Status); end
    RST = 1'b0;
    fd0 = fd_cnt; small_frame();
    checks++; if (fd_cnt - fd0 !== 0 || Frets !== 5'b0) begin errors++; $display("FAIL rst_arm: got fd %0d frets %b want 0/00000", fd_cnt - fd0, Frets); end
    fd0 = fd_cnt; small_frame();
    checks++; if (fd_cnt - fd0 !== 1 || Frets !== 5'b0) begin errors++; $display("FAIL rst_partial: got fd %0d frets %b want 1/00000", fd_cnt - fd0, Frets); end
    small_frame();
    checks++; if (Frets !== 5'b00001 || Strum !== 1'b1) begin errors++; $display("FAIL rst_press: got %b/%b want 00001/1", Frets, Strum); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_chord_change();
    test_threshold();
    test_alternate();
    test_edge();
    test_reset_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
